riscv_bpu: RTL and testbench

Dynamic branch predictor for the RV64 fetch stage: a direct-mapped table of 2-bit saturating counters plus a tagged branch target buffer (BTB). It turns the fetch PC into a same-cycle taken/target prediction. It is trained one cycle-registered write at a time from the execute-stage branch resolution, the taken outcome of the branch comparator. After reset or flush, a sweep FSM clears the tables one entry per cycle before predictions are enabled.

---
 rtl/riscv_bpu_pkg.sv | 27 ++
 rtl/riscv_bpu_sat2.sv | 19 +
 rtl/riscv_bpu.sv | 91 +++++++++
 tb/tb_riscv_bpu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bpu_pkg.sv
// rtl/riscv_bpu_pkg.sv - shared encodings and PC field helpers for the branch predictor
package riscv_bpu_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST = CTR_WNT;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Word-aligned PC: bits [1:0] never take part in indexing or tagging.
    function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
        return (pc >> 2) & ((64'd1 << idx_w) - 64'd1);
    endfunction

    function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w, input int tag_w);
        return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
    endfunction

endpackage

// File: rtl/riscv_bpu_sat2.sv
// rtl/riscv_bpu_sat2.sv - 2-bit saturating counter next-state
module riscv_bpu_sat2
    import riscv_bpu_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken && ctr != CTR_ST) begin
            ctr_next = ctr + 2'd1;
        end else if (!taken && ctr != CTR_SNT) begin
            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/riscv_bpu.sv
// rtl/riscv_bpu.sv - direct-mapped 2-bit counter predictor with tagged BTB and clear sweep
module riscv_bpu
    import riscv_bpu_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int TAG_W = 10
) (
    input  logic        i_riscv_bpu_clk,
    input  logic        i_riscv_bpu_rst_n,
    input  logic        i_riscv_bpu_flush,
    input  logic [63:0] i_riscv_bpu_pc,
    output logic        o_riscv_bpu_taken,
    output logic [63:0] o_riscv_bpu_target,
    output logic        o_riscv_bpu_ready,
    input  logic        i_riscv_bpu_upd_valid,
    input  logic [63:0] i_riscv_bpu_upd_pc,
    input  logic        i_riscv_bpu_upd_taken,
    input  logic [63:0] i_riscv_bpu_upd_target
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state;
    logic [IDX_W-1:0]   clr_idx;

    logic [1:0]         ctr_q [DEPTH];
    logic [DEPTH-1:0]   val_q;
    logic [TAG_W-1:0]   tag_q [DEPTH];
    logic [63:0]        tgt_q [DEPTH];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic [1:0]         ctr_next;
    logic               sweep_we;
    logic               upd_we;
    logic               hit;

    assign idx     = IDX_W'(pc_index(i_riscv_bpu_pc, IDX_W));
    assign tag     = TAG_W'(pc_tag(i_riscv_bpu_pc, IDX_W, TAG_W));
    assign upd_idx = IDX_W'(pc_index(i_riscv_bpu_upd_pc, IDX_W));
    assign upd_tag = TAG_W'(pc_tag(i_riscv_bpu_upd_pc, IDX_W, TAG_W));

    assign o_riscv_bpu_ready = (state == ST_RUN);

    assign sweep_we = (state == ST_INIT) && !i_riscv_bpu_flush;
    assign upd_we   = i_riscv_bpu_upd_valid && o_riscv_bpu_ready && !i_riscv_bpu_flush;

    // Lookup reads only registered state, so a same-cycle update is seen next cycle.
    assign hit                = o_riscv_bpu_ready && val_q[idx] && (tag_q[idx] == tag) && ctr_q[idx][1];
    assign o_riscv_bpu_taken  = hit;
    assign o_riscv_bpu_target = hit ? tgt_q[idx] : 64'd0;

    riscv_bpu_sat2 u_sat2 (
        .ctr      (ctr_q[upd_idx]),
        .taken    (i_riscv_bpu_upd_taken),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge i_riscv_bpu_clk or negedge i_riscv_bpu_rst_n) begin
        if (!i_riscv_bpu_rst_n) begin
            state   <= ST_INIT;
            clr_idx <= '0;
        end else if (i_riscv_bpu_flush) begin
            state   <= ST_INIT;
            clr_idx <= '0;
        end else if (state == ST_INIT) begin
            clr_idx <= clr_idx + 1'b1;
            if (clr_idx == IDX_W'(DEPTH - 1)) begin
                state <= ST_RUN;
            end
        end
    end

    // Table storage carries no reset; the sweep establishes counters and valid bits.
    always_ff @(posedge i_riscv_bpu_clk) begin
        if (sweep_we) begin
            ctr_q[clr_idx] <= CTR_RST;
            val_q[clr_idx] <= 1'b0;
        end else if (upd_we) begin
            ctr_q[upd_idx] <= ctr_next;
            if (i_riscv_bpu_upd_taken) begin
                val_q[upd_idx] <= 1'b1;
                tag_q[upd_idx] <= upd_tag;
                tgt_q[upd_idx] <= i_riscv_bpu_upd_target;
            end
        end
    end

endmodule

// File: tb/tb_riscv_bpu.sv
// tb/tb_riscv_bpu.sv - scoreboard bench for riscv_bpu against a table-level reference model
module tb_riscv_bpu;

    localparam int DEPTH = 64;
    localparam int TAG_W = 10;
    localparam int IDX_W = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [63:0] pc;
    logic        taken;
    logic [63:0] target;
    logic        ready;
    logic        upd_valid;
    logic [63:0] upd_pc;
    logic        upd_taken;
    logic [63:0] upd_target;

    always #5 clk = ~clk;

    riscv_bpu #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .i_riscv_bpu_clk        (clk),
        .i_riscv_bpu_rst_n      (rst_n),
        .i_riscv_bpu_flush      (flush),
        .i_riscv_bpu_pc         (pc),
        .o_riscv_bpu_taken      (taken),
        .o_riscv_bpu_target     (target),
        .o_riscv_bpu_ready      (ready),
        .i_riscv_bpu_upd_valid  (upd_valid),
        .i_riscv_bpu_upd_pc     (upd_pc),
        .i_riscv_bpu_upd_taken  (upd_taken),
        .i_riscv_bpu_upd_target (upd_target)
    );

    typedef struct {
        logic        ready;
        logic        taken;
        logic [63:0] target;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: whole-table view, sweep treated as an opaque DEPTH-cycle wait.
    int          m_ctr [DEPTH];
    bit          m_val [DEPTH];
    longint      m_tag [DEPTH];
    logic [63:0] m_tgt [DEPTH];
    bit          m_ready;
    int          m_cnt;

    function automatic int m_index(input logic [63:0] p);
        return int'((p >> 2) % DEPTH);
    endfunction

    function automatic longint m_tagof(input logic [63:0] p);
        return longint'((p >> (IDX_W + 2)) % (64'd1 << TAG_W));
    endfunction

    task automatic step(input logic [63:0] p, input logic uv, input logic [63:0] upc,
                        input logic ut, input logic [63:0] utg, input logic fl, input string nm);
        exp_t e;
        int   i;
        pc = p; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utg; flush = fl;
        if (!rst_n) begin
            m_ready = 0;
            m_cnt   = 0;
        end
        i        = m_index(p);
        e.ready  = m_ready;
        e.taken  = m_ready && m_val[i] && (m_tag[i] == m_tagof(p)) && (m_ctr[i] >= 2);
        e.target = e.taken ? m_tgt[i] : 64'd0;
        e.name   = nm;
        exp_q.push_back(e);
        if (rst_n) begin
            if (fl) begin
                m_ready = 0;
                m_cnt   = 0;
            end else if (!m_ready) begin
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    for (int k = 0; k < DEPTH; k++) begin
                        m_ctr[k] = 1;
                        m_val[k] = 0;
                    end
                    m_ready = 1;
                end
            end else if (uv) begin
                i = m_index(upc);
                m_ctr[i] = ut ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : ((m_ctr[i] > 0) ? m_ctr[i] - 1 : 0);
                if (ut) begin
                    m_val[i] = 1;
                    m_tag[i] = m_tagof(upc);
                    m_tgt[i] = utg;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [63:0] p, input string nm);
        step(p, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, nm);
    endtask

    task automatic train(input logic [63:0] upc, input logic ut, input logic [63:0] utg, input string nm);
        step(upc, 1'b1, upc, ut, utg, 1'b0, nm);
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".ready"},  64'(ready),  64'(e.ready));
                check({e.name, ".taken"},  64'(taken),  64'(e.taken));
                check({e.name, ".target"}, target, e.target);
            end
        end
    end

    function automatic logic [63:0] rand_pc();
        return 64'h8000_0000 | (64'($urandom_range(0, 7)) << 2) | (64'($urandom_range(0, 1)) << 8);
    endfunction

    initial begin : stim
        logic [63:0] rt;
        rst_n = 1'b0; flush = 1'b0; pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        m_ready = 0; m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) begin
            m_ctr[k] = 0; m_val[k] = 0; m_tag[k] = 0; m_tgt[k] = '0;
        end
        @(posedge clk); #1;
        repeat (3) look(64'h8000_0010, "reset");
        rst_n = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) look(64'h8000_0010, "sweep");

        train(64'h8000_0010, 1'b1, 64'h8000_0100, "first_train");
        look(64'h8000_0010, "first_hit");
        look(64'h8000_0014, "neighbour_miss");

        train(64'h8000_0010, 1'b0, 64'd0, "sat_nt1");
        train(64'h8000_0010, 1'b0, 64'd0, "sat_nt2");
        look(64'h8000_0010, "sat_zero");
        repeat (3) train(64'h8000_0010, 1'b0, 64'd0, "sat_floor");
        train(64'h8000_0010, 1'b1, 64'h8000_0100, "sat_t1");
        look(64'h8000_0010, "sat_wnt");
        repeat (2) train(64'h8000_0010, 1'b1, 64'h8000_0100, "sat_up");
        look(64'h8000_0010, "sat_st");

        look(64'h8000_0110, "alias_miss");
        train(64'h8000_0110, 1'b1, 64'h8000_0400, "alias_train");
        look(64'h8000_0010, "alias_evicted");
        look(64'h8000_0110, "alias_hit");

        train(64'h8000_0020, 1'b0, 64'd0, "snt_setup");
        step(64'h8000_0020, 1'b1, 64'h8000_0020, 1'b1, 64'h8000_0200, 1'b0, "same_cycle");
        look(64'h8000_0020, "same_cycle_next");

        step(64'h8000_0110, 1'b1, 64'h8000_0110, 1'b1, 64'h8000_0700, 1'b1, "flush_upd");
        for (int c = 0; c < DEPTH; c++) look(64'h8000_0110, "flush_sweep");
        for (int c = 0; c < 8; c++) look(rand_pc(), "post_flush");

        for (int c = 0; c < 1500; c++) begin
            rt = {$urandom(), $urandom()};
            step(rand_pc(), 1'($urandom_range(0, 1)), rand_pc(), 1'($urandom_range(0, 1)), rt,
                 ($urandom_range(0, 299) == 0), "random");
        end
        for (int c = 0; c < DEPTH + 2; c++) look(rand_pc(), "drain");

        rst_n = 1'b0;
        look(64'h8000_0010, "async_reset");
        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) look(64'h8000_0010, "sweep_a");
        rst_n = 1'b0;
        look(64'h8000_0010, "midsweep_reset");
        rst_n = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) look(64'h8000_0010, "sweep_b");
        train(64'h8000_0030, 1'b1, 64'h8000_0300, "final_train");
        look(64'h8000_0030, "final_hit");

        for (int w = 0; w < 8 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
